// File: rtl/fusion_pipe_pkg.sv
// Shared definitions for the fusion 5-stage integer pipeline: hazard
// controller state encoding, default pipeline depth and the bubble word
// that decode_32 injects when the controller requests a NOP.
package fusion_pipe_pkg;

    localparam int DEFAULT_PIPELINE_LENGTH = 5;

    // Instruction word placed into ID/EX whenever a bubble is inserted.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LD_STALL = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_SYS_WAIT = 3'd3,
        ST_FLUSH    = 3'd4
    } hazard_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator between the instruction in EX and the one in ID.
// A load into r0 never creates a hazard, and an unused source field
// (encoded as r0) can therefore never match a real load destination.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rsa,
    input  logic [4:0] id_rsb,
    output logic       ld_use_hazard
);

    logic rd_nonzero;
    logic src_match;

    assign rd_nonzero    = (ex_rd != 5'd0);
    assign src_match     = (ex_rd == id_rsa) || (ex_rd == id_rsb);
    assign ld_use_hazard = ex_mem_read && rd_nonzero && id_valid && src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / flush sequencer for the fusion 5-stage pipeline.
// Outputs are Mealy: they depend on the registered state and the current
// inputs so that a hazard is covered in the same cycle it is detected.
module pipeline_hazard_ctrl
    import fusion_pipe_pkg::*;
#(
    parameter int PIPELINE_LENGTH = DEFAULT_PIPELINE_LENGTH
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       id_valid_in,
    input  logic [4:0] id_rsa_in,
    input  logic [4:0] id_rsb_in,
    input  logic       id_memsync_in,
    input  logic       id_syscall_in,
    input  logic [4:0] ex_rd_in,
    input  logic       ex_mem_read_in,
    input  logic       ex_pc_change_in,
    input  logic       mem_busy_in,
    input  logic       syscall_done_in,
    output logic       stall_if_out,
    output logic       stall_id_out,
    output logic       bubble_ex_out,
    output logic       flush_if_id_out,
    output logic       syscall_req_out,
    output logic       drain_active_out,
    output logic [2:0] state_out
);

    localparam int              CNT_W   = $clog2(PIPELINE_LENGTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPELINE_LENGTH - 1);

    hazard_state_e    state;
    hazard_state_e    state_next;
    logic [CNT_W-1:0] drain_cnt;
    logic [CNT_W-1:0] drain_cnt_next;
    logic [CNT_W-1:0] drain_cnt_inc;
    logic             sys_pending;
    logic             sys_pending_next;
    logic             ld_use_hazard;

    hazard_detect u_hazard_detect (
        .ex_mem_read   (ex_mem_read_in),
        .ex_rd         (ex_rd_in),
        .id_valid      (id_valid_in),
        .id_rsa        (id_rsa_in),
        .id_rsb        (id_rsb_in),
        .ld_use_hazard (ld_use_hazard)
    );

    // Drain counter advances by one and parks at its maximum so a long
    // mem_busy hold can never wrap it back into the middle of the drain.
    assign drain_cnt_inc = (drain_cnt == CNT_MAX) ? CNT_MAX : drain_cnt + CNT_W'(1);

    assign state_out = state;

    // State, drain counter and pending-syscall flag; reset abandons any sequence.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            sys_pending <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            sys_pending <= sys_pending_next;
        end
    end

    // Next-state and control outputs; a taken PC change outranks everything in RUN.
    always_comb begin
        state_next       = state;
        drain_cnt_next   = drain_cnt;
        sys_pending_next = sys_pending;
        stall_if_out     = 1'b0;
        stall_id_out     = 1'b0;
        bubble_ex_out    = 1'b0;
        flush_if_id_out  = 1'b0;
        syscall_req_out  = 1'b0;
        drain_active_out = 1'b0;

        case (state)
            ST_RUN: begin
                if (ex_pc_change_in) begin
                    flush_if_id_out = 1'b1;
                    state_next      = ST_FLUSH;
                end else if (ld_use_hazard) begin
                    stall_if_out  = 1'b1;
                    stall_id_out  = 1'b1;
                    bubble_ex_out = 1'b1;
                    state_next    = ST_LD_STALL;
                end else if (id_valid_in && (id_memsync_in || id_syscall_in)) begin
                    stall_if_out     = 1'b1;
                    stall_id_out     = 1'b1;
                    bubble_ex_out    = 1'b1;
                    drain_cnt_next   = '0;
                    sys_pending_next = id_syscall_in;
                    state_next       = ST_DRAIN;
                end
            end

            ST_LD_STALL: begin
                state_next = ST_RUN;
            end

            ST_DRAIN: begin
                stall_if_out     = 1'b1;
                stall_id_out     = 1'b1;
                bubble_ex_out    = 1'b1;
                drain_active_out = 1'b1;
                drain_cnt_next   = drain_cnt_inc;
                if ((drain_cnt_inc == CNT_MAX) && !mem_busy_in) begin
                    state_next = sys_pending ? ST_SYS_WAIT : ST_RUN;
                end
            end

            ST_SYS_WAIT: begin
                stall_if_out     = 1'b1;
                stall_id_out     = 1'b1;
                bubble_ex_out    = 1'b1;
                drain_active_out = 1'b1;
                syscall_req_out  = 1'b1;
                if (syscall_done_in) begin
                    sys_pending_next = 1'b0;
                    flush_if_id_out  = 1'b1;
                    state_next       = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                bubble_ex_out = 1'b1;
                state_next    = ST_RUN;
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations, then randomized traffic compared every cycle
// against a phase-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int PL = 5;

    localparam logic [2:0] M_RUN      = 3'd0;
    localparam logic [2:0] M_LD_STALL = 3'd1;
    localparam logic [2:0] M_DRAIN    = 3'd2;
    localparam logic [2:0] M_SYS_WAIT = 3'd3;
    localparam logic [2:0] M_FLUSH    = 3'd4;

    // Packed view: {state[2:0], stall_if, stall_id, bubble_ex, flush, syscall_req, drain_active}
    localparam logic [8:0] V_IDLE     = {3'd0, 6'b000000};
    localparam logic [8:0] V_RUN_STALL = {3'd0, 6'b111000};
    localparam logic [8:0] V_RUN_FLUSH = {3'd0, 6'b000100};
    localparam logic [8:0] V_LD_STALL = {3'd1, 6'b000000};
    localparam logic [8:0] V_DRAIN    = {3'd2, 6'b111001};
    localparam logic [8:0] V_SYS_WAIT = {3'd3, 6'b111011};
    localparam logic [8:0] V_SYS_DONE = {3'd3, 6'b111111};
    localparam logic [8:0] V_FLUSH    = {3'd4, 6'b001000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rsa = 5'd0;
    logic [4:0] id_rsb = 5'd0;
    logic       id_memsync = 1'b0;
    logic       id_syscall = 1'b0;
    logic [4:0] ex_rd = 5'd0;
    logic       ex_mem_read = 1'b0;
    logic       ex_pc_change = 1'b0;
    logic       mem_busy = 1'b0;
    logic       syscall_done = 1'b0;

    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       flush_if_id;
    logic       syscall_req;
    logic       drain_active;
    logic [2:0] state;

    int n_pass = 0;
    int n_total = 0;
    int cyc_n = 0;

    logic [2:0] m_state = M_RUN;
    int         m_drain_cycles = 0;
    logic       m_pending = 1'b0;

    pipeline_hazard_ctrl dut (
        .clk_in           (clk),
        .reset_in         (rst_n),
        .id_valid_in      (id_valid),
        .id_rsa_in        (id_rsa),
        .id_rsb_in        (id_rsb),
        .id_memsync_in    (id_memsync),
        .id_syscall_in    (id_syscall),
        .ex_rd_in         (ex_rd),
        .ex_mem_read_in   (ex_mem_read),
        .ex_pc_change_in  (ex_pc_change),
        .mem_busy_in      (mem_busy),
        .syscall_done_in  (syscall_done),
        .stall_if_out     (stall_if),
        .stall_id_out     (stall_id),
        .bubble_ex_out    (bubble_ex),
        .flush_if_id_out  (flush_if_id),
        .syscall_req_out  (syscall_req),
        .drain_active_out (drain_active),
        .state_out        (state)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dut_vec();
        return {state, stall_if, stall_id, bubble_ex, flush_if_id, syscall_req, drain_active};
    endfunction

    function automatic logic model_hazard();
        return (ex_rd != 5'd0) && ex_mem_read && id_valid &&
               (id_rsa == ex_rd || id_rsb == ex_rd);
    endfunction

    // Expected outputs for the model's current phase and the live inputs.
    function automatic logic [8:0] model_vec();
        logic [8:0] v;
        v = {m_state, 6'b000000};
        case (m_state)
            M_RUN: begin
                if (ex_pc_change) v = V_RUN_FLUSH;
                else if (model_hazard() || (id_valid && (id_memsync || id_syscall))) v = V_RUN_STALL;
            end
            M_DRAIN:    v = V_DRAIN;
            M_SYS_WAIT: v = syscall_done ? V_SYS_DONE : V_SYS_WAIT;
            M_FLUSH:    v = V_FLUSH;
            default:    v = {m_state, 6'b000000};
        endcase
        return v;
    endfunction

    task automatic check_output(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_idle();
        id_valid = 1'b0; id_rsa = 5'd0; id_rsb = 5'd0;
        id_memsync = 1'b0; id_syscall = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_pc_change = 1'b0;
        mem_busy = 1'b0; syscall_done = 1'b0;
    endtask

    // Phase-level model advance: drain ends once enough drain cycles have elapsed and memory is idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = M_RUN;
            m_drain_cycles = 0;
            m_pending = 1'b0;
        end else begin
            case (m_state)
                M_RUN: begin
                    if (ex_pc_change) m_state = M_FLUSH;
                    else if (model_hazard()) m_state = M_LD_STALL;
                    else if (id_valid && (id_memsync || id_syscall)) begin
                        m_state = M_DRAIN;
                        m_drain_cycles = 0;
                        m_pending = id_syscall;
                    end
                end
                M_LD_STALL: m_state = M_RUN;
                M_DRAIN: begin
                    m_drain_cycles = m_drain_cycles + 1;
                    if (m_drain_cycles >= PL - 1 && !mem_busy)
                        m_state = m_pending ? M_SYS_WAIT : M_RUN;
                end
                M_SYS_WAIT: begin
                    if (syscall_done) begin
                        m_pending = 1'b0;
                        m_state = M_FLUSH;
                    end
                end
                M_FLUSH: m_state = M_RUN;
                default: m_state = M_RUN;
            endcase
        end
    end

    // Every cycle, away from the active edge, compare DUT against the model.
    always @(negedge clk) begin
        cyc_n++;
        check_output($sformatf("model_cycle%0d", cyc_n), dut_vec(), model_vec());
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_output("reset_outputs", dut_vec(), V_IDLE);
        #9 rst_n = 1'b1;
        next_cycle();
        check_output("first_run_cycle", dut_vec(), V_IDLE);

        // Load-use on source a: one bubble, then back to RUN.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_valid = 1'b1; id_rsa = 5'd5; id_rsb = 5'd2;
        #2 check_output("ld_use_hit", dut_vec(), V_RUN_STALL);
        next_cycle();
        apply_stimulus_idle();
        #2 check_output("ld_stall_cycle", dut_vec(), V_LD_STALL);
        next_cycle();
        check_output("ld_after_run", dut_vec(), V_IDLE);

        // Load into r0 with an unused source must not stall.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_valid = 1'b1; id_rsa = 5'd0; id_rsb = 5'd0;
        #2 check_output("ld_r0_no_stall", dut_vec(), V_IDLE);
        // Match on source b only.
        ex_rd = 5'd7; id_rsa = 5'd3; id_rsb = 5'd7;
        #2 check_output("ld_use_rsb", dut_vec(), V_RUN_STALL);
        next_cycle();
        apply_stimulus_idle();
        next_cycle();

        // Memsync with memory idle: 1 entry cycle + 4 drain cycles.
        id_valid = 1'b1; id_memsync = 1'b1;
        #2 check_output("memsync_entry", dut_vec(), V_RUN_STALL);
        next_cycle();
        apply_stimulus_idle();
        for (int i = 0; i < PL - 1; i++) begin
            #2 check_output($sformatf("memsync_drain%0d", i), dut_vec(), V_DRAIN);
            next_cycle();
        end
        check_output("memsync_done", dut_vec(), V_IDLE);

        // Memsync with mem_busy held three extra cycles: eight stall cycles total.
        id_valid = 1'b1; id_memsync = 1'b1;
        #2 check_output("busy_entry", dut_vec(), V_RUN_STALL);
        next_cycle();
        apply_stimulus_idle();
        for (int i = 0; i < 7; i++) begin
            mem_busy = (i >= 3 && i <= 5);
            #2 check_output($sformatf("busy_drain%0d", i), dut_vec(), V_DRAIN);
            next_cycle();
        end
        mem_busy = 1'b0;
        check_output("busy_done", dut_vec(), V_IDLE);

        // Syscall: drain, wait for done at cycle 10, flush, bubble, RUN.
        id_valid = 1'b1; id_syscall = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            syscall_done = (c == 10);
            #2;
            if (c == 0) check_output("sys_entry", dut_vec(), V_RUN_STALL);
            else if (c <= 4) check_output($sformatf("sys_drain%0d", c), dut_vec(), V_DRAIN);
            else if (c <= 9) check_output($sformatf("sys_wait%0d", c), dut_vec(), V_SYS_WAIT);
            else if (c == 10) check_output("sys_done", dut_vec(), V_SYS_DONE);
            else if (c == 11) check_output("sys_flush", dut_vec(), V_FLUSH);
            else check_output("sys_back_run", dut_vec(), V_IDLE);
            next_cycle();
            if (c == 0) apply_stimulus_idle();
        end
        apply_stimulus_idle();

        // PC change with a hazard and a memsync in ID: flush wins.
        ex_pc_change = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
        id_valid = 1'b1; id_rsa = 5'd9; id_memsync = 1'b1;
        #2 check_output("pc_change_priority", dut_vec(), V_RUN_FLUSH);
        next_cycle();
        apply_stimulus_idle();
        #2 check_output("pc_change_flush", dut_vec(), V_FLUSH);
        next_cycle();
        check_output("pc_change_run", dut_vec(), V_IDLE);

        // Async reset in the middle of SYS_WAIT.
        id_valid = 1'b1; id_syscall = 1'b1;
        next_cycle();
        apply_stimulus_idle();
        for (int i = 0; i < PL - 1; i++) next_cycle();
        next_cycle();
        check_output("pre_reset_syswait", dut_vec(), V_SYS_WAIT);
        #2 rst_n = 1'b0;
        #1 check_output("reset_mid_syswait", dut_vec(), V_IDLE);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check_output($sformatf("post_reset_idle%0d", i), dut_vec(), V_IDLE);
        end

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rsa       = 5'($urandom_range(0, 7));
            id_rsb       = 5'($urandom_range(0, 7));
            id_memsync   = ($urandom_range(0, 19) == 0);
            id_syscall   = ($urandom_range(0, 19) == 0);
            ex_rd        = 5'($urandom_range(0, 7));
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            ex_pc_change = ($urandom_range(0, 9) == 0);
            mem_busy     = ($urandom_range(0, 9) < 4);
            syscall_done = ($urandom_range(0, 4) == 0);
            next_cycle();
        end

        apply_stimulus_idle();
        for (int i = 0; i < 20; i++) next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
